// File: rtl/bus_arbiter_pkg.sv
// Shared types and default widths for the two-requester bus arbiter.
// The state encoding is common to the top-level FSM and any bench that inspects it.
`timescale 1ns/1ps
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam int DEF_ADDR_W = 7;
   localparam int DEF_DATA_W = 8;

   // Wide enough for the largest legal strobe width (15).
   localparam int CNT_W = 4;

   localparam int REQ_NUM = 2;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/response and external bus signals between the requesters, the arbiter
// and the top-level tristate driver.
`timescale 1ns/1ps
interface bus_arbiter_if
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata;
   logic              busy;

   logic [ADDR_W-1:0] address_bus;
   logic [DATA_W-1:0] data_out;
   logic              data_oe;
   logic [DATA_W-1:0] data_in;
   logic              read_n;
   logic              write_n;

   // Arbiter side.
   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, data_in,
      output ack0, ack1, rdata, busy, address_bus, data_out, data_oe, read_n, write_n
   );

   // Requester / bus-model side.
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, data_in,
      input  ack0, ack1, rdata, busy, address_bus, data_out, data_oe, read_n, write_n
   );

endinterface

// File: rtl/bus_arbiter_rr_arbiter.sv
// Two-way grant selection with a registered grant that doubles as the last-served pointer.
// BUS_ARBITER_RR_EN selects round-robin; undefined gives fixed priority to requester 0.
`timescale 1ns/1ps
module rr_arbiter
   import bus_arbiter_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic req0,
   input  logic req1,
   input  logic grant_en,
   output logic pick,
   output logic grant
);

   logic grant_reg;

`ifdef BUS_ARBITER_RR_EN
   // Reset to "requester 1 served last" so the first tie goes to requester 0.
   localparam logic GRANT_RST = 1'b1;

   always_comb begin
      pick = 1'b0;
      if (req0 && req1)
         pick = ~grant_reg;
      else if (req1)
         pick = 1'b1;
   end
`else
   localparam logic GRANT_RST = 1'b0;

   always_comb begin
      pick = 1'b0;
      if (!req0 && req1)
         pick = 1'b1;
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset_n)
         grant_reg <= GRANT_RST;
      else if (grant_en)
         grant_reg <= pick;
   end

   assign grant = grant_reg;

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus access FSM (IDLE/SETUP/STROBE/HOLD) serving two requesters with
// registered bus outputs; arbitration policy set by BUS_ARBITER_RR_EN in rr_arbiter.
`timescale 1ns/1ps
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int STROBE_CYCLES = 2
)(
   input  logic clk,
   input  logic reset_n,
   bus_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STROBE_CYCLES - 1);

   state_t            state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              we_reg;
   logic [ADDR_W-1:0] address_bus_reg;
   logic [DATA_W-1:0] data_out_reg;
   logic              data_oe_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              read_n_reg;
   logic              write_n_reg;
   logic              ack0_reg;
   logic              ack1_reg;
   logic              busy_reg;

   logic              start;
   logic              pick;
   logic              grant;
   logic [ADDR_W-1:0] pick_addr;
   logic              pick_we;
   logic [DATA_W-1:0] pick_wdata;

   assign start      = (state_reg == IDLE) && (bus.req0 || bus.req1);
   assign pick_addr  = pick ? bus.addr1  : bus.addr0;
   assign pick_we    = pick ? bus.we1    : bus.we0;
   assign pick_wdata = pick ? bus.wdata1 : bus.wdata0;

   rr_arbiter u_arb (
      .clk      (clk),
      .reset_n  (reset_n),
      .req0     (bus.req0),
      .req1     (bus.req1),
      .grant_en (start),
      .pick     (pick),
      .grant    (grant)
   );

   // All bus outputs are registered here so the pins change only on clock edges.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         we_reg          <= 1'b0;
         address_bus_reg <= '0;
         data_out_reg    <= '0;
         data_oe_reg     <= 1'b0;
         rdata_reg       <= '0;
         read_n_reg      <= 1'b1;
         write_n_reg     <= 1'b1;
         ack0_reg        <= 1'b0;
         ack1_reg        <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         ack0_reg <= 1'b0;
         ack1_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg       <= SETUP;
                  busy_reg        <= 1'b1;
                  we_reg          <= pick_we;
                  address_bus_reg <= pick_addr;
                  data_oe_reg     <= pick_we;
                  data_out_reg    <= pick_we ? pick_wdata : '0;
               end
            end
            SETUP: begin
               state_reg   <= STROBE;
               cnt_reg     <= '0;
               read_n_reg  <= we_reg;
               write_n_reg <= ~we_reg;
            end
            STROBE: begin
               if (cnt_reg == LAST_CNT) begin
                  state_reg   <= HOLD;
                  read_n_reg  <= 1'b1;
                  write_n_reg <= 1'b1;
                  ack0_reg    <= ~grant;
                  ack1_reg    <= grant;
                  // Read data is sampled on the edge that closes the strobe.
                  if (!we_reg)
                     rdata_reg <= bus.data_in;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            HOLD: begin
               state_reg       <= IDLE;
               busy_reg        <= 1'b0;
               address_bus_reg <= '0;
               data_oe_reg     <= 1'b0;
               data_out_reg    <= '0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.ack0        = ack0_reg;
   assign bus.ack1        = ack1_reg;
   assign bus.rdata       = rdata_reg;
   assign bus.busy        = busy_reg;
   assign bus.address_bus = address_bus_reg;
   assign bus.data_out    = data_out_reg;
   assign bus.data_oe     = data_oe_reg;
   assign bus.read_n      = read_n_reg;
   assign bus.write_n     = write_n_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table of single transactions plus
// hand-written tie, late-request, mid-transaction reset and strobe-width sequences.
`timescale 1ns/1ps
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   localparam int AW = 7;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus   ();
   bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1  ();
   bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus15 ();

   bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(2))  dut   (.clk(clk), .reset_n(reset_n), .bus(bus));
   bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(1))  dut1  (.clk(clk), .reset_n(reset_n), .bus(bus1));
   bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(15)) dut15 (.clk(clk), .reset_n(reset_n), .bus(bus15));

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          r;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] din;
      logic [AW-1:0] e_addr;
      int            e_oe;
      logic [DW-1:0] e_dout;
      logic [DW-1:0] e_rdata;
      int            e_wlow;
      int            e_rlow;
      int            e_lat;
   } vec_t;

   vec_t vecs[6];

   task automatic run_txn(input logic r, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] din,
                          output int lat, output int wlow, output int rlow, output int oe_cnt,
                          output int both, output int wrong,
                          output logic [AW-1:0] a_seen, output logic [DW-1:0] dout_seen,
                          output logic [DW-1:0] rdata_seen);
      lat = -1; wlow = 0; rlow = 0; oe_cnt = 0; both = 0; wrong = 0;
      a_seen = '0; dout_seen = '0; rdata_seen = '0;
      @(negedge clk);
      bus.data_in = din;
      if (r) begin
         bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
      end else begin
         bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
      end
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (!bus.write_n) wlow++;
         if (!bus.read_n) rlow++;
         if (!bus.write_n && !bus.read_n) both++;
         if (bus.data_oe) oe_cnt++;
         if (!bus.write_n || !bus.read_n) begin
            a_seen    = bus.address_bus;
            dout_seen = bus.data_out;
         end
         if (r ? bus.ack0 : bus.ack1) wrong++;
         if (r ? bus.ack1 : bus.ack0) begin
            lat        = c;
            rdata_seen = bus.rdata;
            break;
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int lat, wlow, rlow, oe_cnt, both, wrong;
      logic [AW-1:0] a_seen;
      logic [DW-1:0] dout_seen, rdata_seen;
      int exp_g[5];
      int n, gap, idle_cnt, found, acks, w1, w15, lat1, lat15;
      logic [1:0] order [2];

      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0; bus.data_in = '0;
      bus1.req0 = 0; bus1.req1 = 0; bus1.we0 = 0; bus1.we1 = 0;
      bus1.addr0 = '0; bus1.addr1 = '0; bus1.wdata0 = '0; bus1.wdata1 = '0; bus1.data_in = '0;
      bus15.req0 = 0; bus15.req1 = 0; bus15.we0 = 0; bus15.we1 = 0;
      bus15.addr0 = '0; bus15.addr1 = '0; bus15.wdata0 = '0; bus15.wdata1 = '0; bus15.data_in = '0;

      //            r     we    addr   wdata  din    e_addr e_oe e_dout e_rdata wlow rlow lat
      vecs[0] = '{1'b0, 1'b1, 7'h01, 8'hF3, 8'h00, 7'h01, 4, 8'hF3, 8'h00, 2, 0, 4};
      vecs[1] = '{1'b1, 1'b0, 7'h05, 8'h00, 8'hAA, 7'h05, 0, 8'h00, 8'hAA, 0, 2, 4};
      vecs[2] = '{1'b1, 1'b1, 7'h7F, 8'h5A, 8'h11, 7'h7F, 4, 8'h5A, 8'hAA, 2, 0, 4};
      vecs[3] = '{1'b0, 1'b0, 7'h00, 8'h77, 8'h3C, 7'h00, 0, 8'h00, 8'h3C, 0, 2, 4};
      vecs[4] = '{1'b0, 1'b0, 7'h2A, 8'h00, 8'hFF, 7'h2A, 0, 8'h00, 8'hFF, 0, 2, 4};
      vecs[5] = '{1'b0, 1'b1, 7'h40, 8'h00, 8'h55, 7'h40, 4, 8'h00, 8'hFF, 2, 0, 4};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_read_n", bus.read_n, 1);
      check("rst_write_n", bus.write_n, 1);
      check("rst_data_oe", bus.data_oe, 0);
      check("rst_address_bus", bus.address_bus, 0);
      check("rst_data_out", bus.data_out, 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_ack0", bus.ack0, 0);
      check("rst_ack1", bus.ack1, 0);
      check("rst_busy", bus.busy, 0);
      reset_n = 1'b1;

      // Single transactions from the vector table
      foreach (vecs[i]) begin
         run_txn(vecs[i].r, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].din,
                 lat, wlow, rlow, oe_cnt, both, wrong, a_seen, dout_seen, rdata_seen);
         $display("vec %0d: r=%0d we=%0d addr=0x%0h lat=%0d wlow=%0d rlow=%0d rdata=0x%0h",
                  i, vecs[i].r, vecs[i].we, vecs[i].addr, lat, wlow, rlow, rdata_seen);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].e_lat);
         check($sformatf("vec%0d_write_n_low", i), wlow, vecs[i].e_wlow);
         check($sformatf("vec%0d_read_n_low", i), rlow, vecs[i].e_rlow);
         check($sformatf("vec%0d_data_oe_cycles", i), oe_cnt, vecs[i].e_oe);
         check($sformatf("vec%0d_address_bus", i), a_seen, vecs[i].e_addr);
         if (vecs[i].we)
            check($sformatf("vec%0d_data_out", i), dout_seen, vecs[i].e_dout);
         check($sformatf("vec%0d_rdata", i), rdata_seen, vecs[i].e_rdata);
         check($sformatf("vec%0d_both_strobes", i), both, 0);
         check($sformatf("vec%0d_wrong_ack", i), wrong, 0);
         check($sformatf("vec%0d_idle_busy", i), bus.busy, 0);
         check($sformatf("vec%0d_idle_addr", i), bus.address_bus, 0);
      end

      // Tie with both requests held; reset first so the pointer favours requester 0
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
`ifdef BUS_ARBITER_RR_EN
      exp_g = '{0, 1, 0, 1, 1};
`else
      exp_g = '{0, 0, 0, 0, 1};
`endif
      bus.we0 = 1; bus.we1 = 1; bus.addr0 = 7'h11; bus.addr1 = 7'h22;
      bus.wdata0 = 8'hA0; bus.wdata1 = 8'hB1;
      bus.req0 = 1; bus.req1 = 1;
      n = 0; gap = 0; idle_cnt = 0;
      for (int c = 0; c < 80 && n < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         gap++;
         if (!bus.busy) idle_cnt++;
         if (bus.ack0 || bus.ack1) begin
            $display("tie grant %0d: ack0=%0d ack1=%0d addr=0x%0h gap=%0d", n, bus.ack0, bus.ack1, bus.address_bus, gap);
            check($sformatf("tie%0d_grant", n), bus.ack1, exp_g[n]);
            check($sformatf("tie%0d_single_ack", n), bus.ack0 & bus.ack1, 0);
            check($sformatf("tie%0d_address", n), bus.address_bus, bus.ack1 ? 7'h22 : 7'h11);
            if (n > 0 && n < 4) begin
               check($sformatf("tie%0d_gap", n), gap, 5);
               check($sformatf("tie%0d_idle_cycles", n), idle_cnt, 1);
            end
            gap = 0; idle_cnt = 0;
            n++;
            if (n == 4) bus.req0 = 0;
            if (n == 5) bus.req1 = 0;
         end
      end
      check("tie_grant_count", n, 5);
      bus.req0 = 0; bus.req1 = 0;
      repeat (3) @(negedge clk);

      // Request arriving mid-transaction waits; latched inputs ignore later changes
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 7'h10; bus.wdata0 = 8'hC3;
      @(negedge clk);
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 7'h20; bus.data_in = 8'h99;
      bus.addr0 = 7'h6E; bus.wdata0 = 8'h0F;
      acks = 0;
      for (int c = 0; c < 40 && acks < 2; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.ack0 || bus.ack1) begin
            order[acks] = {bus.ack1, bus.ack0};
            $display("late ack %0d: ack0=%0d ack1=%0d addr=0x%0h dout=0x%0h rdata=0x%0h",
                     acks, bus.ack0, bus.ack1, bus.address_bus, bus.data_out, bus.rdata);
            if (acks == 0) begin
               check("late_first_ack", {bus.ack1, bus.ack0}, 2'b01);
               check("late_first_addr", bus.address_bus, 7'h10);
               check("late_first_dout", bus.data_out, 8'hC3);
               bus.req0 = 0;
            end else begin
               check("late_second_ack", {bus.ack1, bus.ack0}, 2'b10);
               check("late_second_addr", bus.address_bus, 7'h20);
               check("late_second_rdata", bus.rdata, 8'h99);
               bus.req1 = 0;
            end
            acks++;
         end
      end
      check("late_ack_count", acks, 2);
      bus.req0 = 0; bus.req1 = 0;
      repeat (3) @(negedge clk);

      // Reset during the strobe of a write aborts it
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 7'h33; bus.wdata0 = 8'h44;
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (!bus.write_n) found = 1;
      end
      check("abort_strobe_seen", found, 1);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      $display("abort: write_n=%0d data_oe=%0d busy=%0d ack0=%0d", bus.write_n, bus.data_oe, bus.busy, bus.ack0);
      check("abort_write_n", bus.write_n, 1);
      check("abort_data_oe", bus.data_oe, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_ack0", bus.ack0, 0);
      check("abort_address_bus", bus.address_bus, 0);
      bus.req0 = 0;
      @(negedge clk);
      reset_n = 1'b1;
      acks = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.ack0) acks++;
      end
      check("abort_no_late_ack", acks, 0);

      // Strobe width and latency with STROBE_CYCLES of 1 and 15
      bus1.req0 = 1;  bus1.we0 = 1;  bus1.addr0 = 7'h01;  bus1.wdata0 = 8'hF3;
      bus15.req0 = 1; bus15.we0 = 1; bus15.addr0 = 7'h01; bus15.wdata0 = 8'hF3;
      w1 = 0; w15 = 0; lat1 = -1; lat15 = -1;
      for (int c = 1; c <= 25; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (!bus1.write_n) w1++;
         if (!bus15.write_n) w15++;
         if (bus1.ack0 && lat1 < 0) begin lat1 = c; bus1.req0 = 0; end
         if (bus15.ack0 && lat15 < 0) begin lat15 = c; bus15.req0 = 0; end
      end
      $display("param: sc1 width=%0d lat=%0d, sc15 width=%0d lat=%0d", w1, lat1, w15, lat15);
      check("sc1_strobe_width", w1, 1);
      check("sc1_latency", lat1, 3);
      check("sc15_strobe_width", w15, 15);
      check("sc15_latency", lat15, 17);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
